// File: rtl/compa2_pkg.sv
// Shared types and helpers for the compa2 negation arbiter.
// Holds the output-register state encoding and the most-negative operand constant.
package compa2_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Bit pattern 1 followed by w-1 zeros: the one operand whose negation overflows.
    function automatic int unsigned min_neg(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/compa2_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid requester after ptr_i wins,
// with the search wrapping around modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] grant_idx_o,
    output logic [N-1:0]   grant_oh_o,
    output logic           any_o
);

    // cand[k] is the k-th requester in search order, starting at ptr_i+1.
    logic [IDW-1:0] cand [N];
    logic           found;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IDW'((int'(ptr_i) + gi + 1) % N);
    end

    assign any_o = |valid_i;

    always_comb begin
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && valid_i[cand[k]]) begin
                found       = 1'b1;
                grant_idx_o = cand[k];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign grant_oh_o[gi] = any_o && (grant_idx_o == IDW'(gi));
    end

endmodule

// File: rtl/compa2_arbiter.sv
// N requesters share one registered two's-complement negation unit; a round-robin
// picker chooses one operand per load and the result returns with its requester ID.
module compa2_arbiter
    import compa2_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [W-1:0]   resp_data,
    output logic [IDW-1:0] resp_id,
    output logic           resp_ovf
);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [W-1:0]   data_q, data_d;
    logic [IDW-1:0] id_q, id_d;
    logic           ovf_q, ovf_d;

    logic [IDW-1:0] grant_idx;
    logic [N-1:0]   grant_oh;
    logic           any_valid;
    logic           load;
    logic [W-1:0]   ops [N];
    logic [W-1:0]   op;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign ops[gi] = req_data[gi*W +: W];
    end

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .valid_i     (req_valid),
        .ptr_i       (ptr_q),
        .grant_idx_o (grant_idx),
        .grant_oh_o  (grant_oh),
        .any_o       (any_valid)
    );

    // The slot can take a new operand when empty or when its current result leaves now.
    assign load      = any_valid && (state_q == EMPTY || resp_ready) && !reset;
    assign req_ready = load ? grant_oh : '0;
    assign op        = ops[grant_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        if (load) begin
            state_d = FULL;
            ptr_d   = grant_idx;
            data_d  = ~op + W'(1);
            id_d    = grant_idx;
            ovf_d   = (op == W'(min_neg(W)));
        end else if (state_q == FULL && resp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= IDW'(N - 1);
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign resp_ovf   = ovf_q;

endmodule

// File: tb/tb_compa2_arbiter.sv
// Randomised scoreboard bench for compa2_arbiter: requester queues feed a
// round-robin reference model that predicts grants and negated results.
module tb_compa2_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = $clog2(N);
    localparam int QD  = 64;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [IDW-1:0] resp_id;
    logic           resp_ovf;

    compa2_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ovf   (resp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic           ovf;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] opq [N][QD];
    int           hd [N];
    int           tl [N];
    int           mptr;
    bit           holding;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic enq(input int i, input logic [W-1:0] v);
        opq[i][tl[i] % QD] = v;
        tl[i]++;
    endtask

    task automatic present(output logic [N-1:0] v);
        v        = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            if (hd[i] != tl[i]) begin
                v[i] = 1'b1;
                req_data[i*W +: W] = opq[i][hd[i] % QD];
            end
        end
        req_valid = v;
    endtask

    // One clock of traffic; entered and left 1 time unit after a rising edge.
    task automatic do_cycle(input bit rdy);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] op;
        int           g;
        bit           ld;
        exp_t         e;
        present(v);
        resp_ready = rdy;
        #1;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
        end
        ld      = (g >= 0) && (!holding || rdy);
        exp_rdy = ld ? (N'(1) << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(holding));
        if (ld) begin
            op    = opq[g][hd[g] % QD];
            hd[g]++;
            e.d   = W'((1 << W) - int'(op));
            e.id  = IDW'(g);
            e.ovf = (int'(op) == (1 << (W - 1)));
            sb.push_back(e);
            mptr    = g;
            holding = 1'b1;
        end else if (rdy) begin
            holding = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        logic [N-1:0] v;
        reset      = 1'b1;
        resp_ready = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            present(v);
            #1;
            chk("req_ready_in_reset", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        sb.delete();
        mptr    = N - 1;
        holding = 1'b0;
    endtask

    task automatic random_traffic(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hd[i] == tl[i] && $urandom_range(0, 3) != 0) enq(i, W'($urandom));
            end
            do_cycle($urandom_range(0, 3) != 0);
        end
    endtask

    // Monitor: every consumed response is compared against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got id %0d data %0h, expected nothing", resp_id, resp_data);
            end else begin
                e = sb.pop_front();
                $display("resp id=%0d data=%0h ovf=%0b", resp_id, resp_data, resp_ovf);
                chk("resp_data", 32'(resp_data), 32'(e.d));
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        @(posedge clk);
        #1;
        do_reset(2);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", 32'(resp_data), 32'd0);
        chk("reset_resp_id", 32'(resp_id), 32'd0);
        chk("reset_resp_ovf", 32'(resp_ovf), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        do_cycle(1);

        // Single requester 1 with operand 0011.
        enq(1, 4'b0011);
        do_cycle(1);
        do_cycle(1);

        // Round-robin from reset: grants 0,1,2,3,0.
        do_reset(1);
        enq(0, 4'b0001); enq(1, 4'b0010); enq(2, 4'b0011); enq(3, 4'b0100); enq(0, 4'b0001);
        repeat (6) do_cycle(1);

        // Back-pressure with requester 2's result pending and requester 3 waiting.
        do_reset(1);
        enq(2, 4'b0101);
        do_cycle(1);
        enq(3, 4'b0110);
        repeat (3) do_cycle(0);
        repeat (2) do_cycle(1);

        // Boundary operands.
        enq(0, 4'b1000); enq(0, 4'b0000); enq(0, 4'b1111);
        repeat (5) do_cycle(1);

        random_traffic(400);

        // Reset with a result pending and all requesters valid.
        for (int i = 0; i < N; i++) if (hd[i] == tl[i]) enq(i, W'($urandom));
        do_cycle(0);
        do_cycle(0);
        do_reset(1);
        random_traffic(300);

        guard = 0;
        while (guard < 100) begin
            bit busy;
            busy = holding;
            for (int i = 0; i < N; i++) if (hd[i] != tl[i]) busy = 1'b1;
            if (!busy) break;
            do_cycle(1);
            guard++;
        end
        do_cycle(1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_resp_valid", 32'(resp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
